// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy scoreboard for the 8x8 register file and CB; WB_ARB_ROUND_ROBIN_EN selects round-robin over fixed A priority.
// One registered stage (handshake in N strobes the file in N+1); ready drops on hold_i or reset and the losing port stalls until granted.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                hold_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  input  logic                a_we_i,
  input  logic [ADDR_W-1:0]   a_addr_i,
  input  logic [DATA_W-1:0]   a_data_i,
  input  logic                a_cb_we_i,
  input  logic                a_cb_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic                b_we_i,
  input  logic [ADDR_W-1:0]   b_addr_i,
  input  logic [DATA_W-1:0]   b_data_i,
  input  logic                b_cb_we_i,
  input  logic                b_cb_i,
  input  logic                rsv_i,
  input  logic [ADDR_W-1:0]   rsv_addr_i,
  input  logic                rsv_cb_i,
  output logic                write_o,
  output logic [ADDR_W-1:0]   write_addr_o,
  output logic [DATA_W-1:0]   write_data_o,
  output logic                write_cb_o,
  output logic                cb_data_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                cb_busy_o
);

  logic                a_fire;
  logic                b_fire;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                cb_busy_nxt;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic last_b;
`endif

  always_comb begin
    a_ready_o = 1'b0;
    b_ready_o = 1'b0;
    if (reset_n_i && !hold_i) begin
      if (a_valid_i && b_valid_i) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        a_ready_o = last_b;
        b_ready_o = !last_b;
`else
        a_ready_o = 1'b1;
`endif
      end else begin
        a_ready_o = a_valid_i;
        b_ready_o = b_valid_i;
      end
    end
  end

  assign a_fire = a_valid_i && a_ready_o;
  assign b_fire = b_valid_i && b_ready_o;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Pointer remembers the last winner; it only moves on a completed handshake.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_b <= 1'b1;
    end else if (a_fire) begin
      last_b <= 1'b0;
    end else if (b_fire) begin
      last_b <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      write_o      <= 1'b0;
      write_addr_o <= '0;
      write_data_o <= '0;
      write_cb_o   <= 1'b0;
      cb_data_o    <= 1'b0;
    end else if (a_fire) begin
      write_o      <= a_we_i;
      write_addr_o <= a_addr_i;
      write_data_o <= a_data_i;
      write_cb_o   <= a_cb_we_i;
      cb_data_o    <= a_cb_i;
    end else if (b_fire) begin
      write_o      <= b_we_i;
      write_addr_o <= b_addr_i;
      write_data_o <= b_data_i;
      write_cb_o   <= b_cb_we_i;
      cb_data_o    <= b_cb_i;
    end else begin
      write_o      <= 1'b0;
      write_cb_o   <= 1'b0;
    end
  end

  // Commit clears first so a same-cycle reservation of that register survives.
  always_comb begin
    busy_nxt = busy_o;
    if (write_o) begin
      busy_nxt[write_addr_o] = 1'b0;
    end
    if (rsv_i) begin
      busy_nxt[rsv_addr_i] = 1'b1;
    end
    cb_busy_nxt = (cb_busy_o && !write_cb_o) || rsv_cb_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      busy_o    <= '0;
      cb_busy_o <= 1'b0;
    end else begin
      busy_o    <= busy_nxt;
      cb_busy_o <= cb_busy_nxt;
    end
  end

endmodule
